// File: rtl/ppc_disp_pkg.sv
// Shared constants for the ping-pong counter display stage.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package ppc_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_UP    = 7'b1011100;  // a,b,f lit
  localparam logic [6:0] SEG_DOWN  = 7'b1100011;  // c,d,e lit

  // Index 0 is the rightmost (least significant) slice.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam logic [1:0] DIG_UNITS  = 2'd0;
  localparam logic [1:0] DIG_TENS   = 2'd1;
  localparam logic [1:0] DIG_DIR_LO = 2'd2;
  localparam logic [1:0] DIG_DIR_HI = 2'd3;

  // Units digit of a 0..15 value without a divider.
  function automatic logic [3:0] units_of(input logic [3:0] v);
    return (v >= 4'd10) ? v - 4'd10 : v;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD to seven-segment decoder, active-low outputs.
// Ports:
//   digit : 4-bit decimal digit (values above 9 decode to blank)
//   blank : force all segments off
//   seg   : {g,f,e,d,c,b,a}, active-low
module seven_seg_decoder
  import ppc_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && digit <= 4'd9) seg = SEG_DIGITS[digit];
  end

endmodule

// File: rtl/ppc_seven_seg_display.sv
// Four-digit multiplexed common-anode display for the ping-pong counter.
// Digits 3..2 show a direction glyph, digits 1..0 show value as "00".."15".
// Inputs are snapshotted once per scan frame (scan counter == 0).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   value       : 4-bit counter value
//   direction   : 1 = up, 0 = down
//   an          : digit enables, active-low
//   seg         : segments {g,f,e,d,c,b,a}, active-low
//   frame_start : one-cycle pulse, high in the cycle the new snapshot is shown
// Build option: define PPC_DISP_BLANK_LZ_EN to darken the tens digit when
// the value is below 10 (its anode stays enabled).
module ppc_seven_seg_display
  import ppc_disp_pkg::*;
#(
  parameter int REFRESH_BITS = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] value,
  input  logic       direction,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_start
);

  logic [REFRESH_BITS-1:0] cnt;
  logic [1:0]              sel;
  logic                    frame_now;
  logic [3:0]              snap_val;
  logic                    snap_dir;
  logic [3:0]              cur_val;
  logic                    cur_dir;
  logic [3:0]              dec_digit;
  logic                    dec_blank;
  logic [6:0]              dec_seg;
  logic [6:0]              seg_nxt;
  logic [3:0]              an_nxt;

  assign sel       = cnt[REFRESH_BITS-1:REFRESH_BITS-2];
  assign frame_now = (cnt == '0);

  // At counter 0 the output register is loaded from the live inputs, so the
  // first digit of a frame already reflects the snapshot being captured.
  assign cur_val = frame_now ? value     : snap_val;
  assign cur_dir = frame_now ? direction : snap_dir;

  seven_seg_decoder u_dec (
    .digit (dec_digit),
    .blank (dec_blank),
    .seg   (dec_seg)
  );

  always_comb begin
    dec_digit = units_of(cur_val);
    dec_blank = 1'b0;
    seg_nxt   = dec_seg;
    an_nxt    = ~(4'b0001 << sel);
    case (sel)
      DIG_UNITS: dec_digit = units_of(cur_val);
      DIG_TENS: begin
        dec_digit = {3'b000, cur_val >= 4'd10};
`ifdef PPC_DISP_BLANK_LZ_EN
        dec_blank = (cur_val < 4'd10);
`endif
      end
      default: seg_nxt = cur_dir ? SEG_UP : SEG_DOWN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      snap_val    <= 4'd0;
      snap_dir    <= 1'b1;
      an          <= 4'b1111;
      seg         <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt + 1'b1;
      if (frame_now) begin
        snap_val <= value;
        snap_dir <= direction;
      end
      an          <= an_nxt;
      seg         <= seg_nxt;
      frame_start <= frame_now;
    end
  end

endmodule

// File: tb/tb_ppc_seven_seg_display.sv
module tb_ppc_seven_seg_display;

  localparam int RB = 4;  // 4 cycles per digit, 16-cycle frame

  typedef logic [3:0][6:0] frame_t;  // expected seg per digit 0..3

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] value = 4'd0;
  logic       direction = 1'b1;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_start;

  int     checks = 0;
  int     failures = 0;
  bit     mon_en = 1'b0;
  frame_t exp_q[$];

  ppc_seven_seg_display #(.REFRESH_BITS(RB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .direction   (direction),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dec7(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic frame_t model(input int v, input bit d);
    frame_t f;
    f[0] = dec7(v % 10);
    f[1] = dec7(v / 10);
`ifdef PPC_DISP_BLANK_LZ_EN
    if (v < 10) f[1] = 7'b1111111;
`endif
    f[2] = d ? 7'b1011100 : 7'b1100011;
    f[3] = f[2];
    return f;
  endfunction

  // Wait for the next frame_start, bounded.
  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 64);
    if (!frame_start) begin
      checks++;
      failures++;
      $display("FAIL frame_start_timeout: no pulse within %0d cycles", n);
    end
  endtask

  // Wait for a frame to start, optionally idle some cycles, then drive new
  // inputs that the following frame must show.
  task automatic run_frame(input int v, input bit d, input int dly, input frame_t e);
    wait_fs();
    repeat (dly) @(negedge clk);
    #2;
    value     = 4'(v);
    direction = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: each frame_start pops one expected frame and checks
  // all 16 cycles of it.
  initial begin : monitor
    frame_t     e;
    logic [3:0] ea;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && frame_start) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL frame_unexpected: frame_start with empty queue at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            ea = ~(4'b0001 << (i / 4));
            chk("frame_an", {3'b000, an}, {3'b000, ea});
            chk("frame_seg", seg, e[i/4]);
            chk("frame_pulse", {6'b0, frame_start}, {6'b0, i == 0});
          end
        end
      end
    end
  end

  frame_t f7, f13;
  initial begin : stim
    int n;
    // Hand-computed frames for value 7/up and 13/down.
    f7[0] = 7'b1111000;
`ifdef PPC_DISP_BLANK_LZ_EN
    f7[1] = 7'b1111111;
`else
    f7[1] = 7'b1000000;
`endif
    f7[2] = 7'b1011100;
    f7[3] = 7'b1011100;
    f13[0] = 7'b0110000;
    f13[1] = 7'b1111001;
    f13[2] = 7'b1100011;
    f13[3] = 7'b1100011;

    value = 4'd7;
    direction = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_an", {3'b000, an}, 7'b0001111);
    chk("reset_seg", seg, 7'b1111111);
    chk("reset_pulse", {6'b0, frame_start}, 7'd0);

    // First frame after release captures value 7 / up.
    exp_q.push_back(f7);
    mon_en = 1'b1;
    #2 rst_n = 1'b1;

    run_frame(13, 1'b0, 0, f13);
    run_frame(3, 1'b1, 0, model(3, 1'b1));
    // Mid-frame change (counter 6): frame of 3 must stay intact.
    run_frame(12, 1'b1, 5, model(12, 1'b1));
    for (int v = 0; v < 16; v++) run_frame(v, 1'b1, 0, model(v, 1'b1));
    for (int v = 15; v >= 0; v--) run_frame(v, 1'b0, 0, model(v, 1'b0));
    wait_fs();
    repeat (15) @(negedge clk);
    #2 mon_en = 1'b0;
    chk("queue_drained", 7'(exp_q.size()), 7'd0);

    // Asynchronous reset while digit 2 is lit.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an !== 4'b1011 && n < 64);
    chk("digit2_reached", {3'b000, an}, 7'b0001011);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", {3'b000, an}, 7'b0001111);
    chk("async_rst_seg", seg, 7'b1111111);
    chk("async_rst_pulse", {6'b0, frame_start}, 7'd0);

    value = 4'd9;
    direction = 1'b0;
    exp_q.push_back(model(9, 1'b0));
    mon_en = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_fs();
    repeat (15) @(negedge clk);
    #2 mon_en = 1'b0;
    chk("queue_drained_rst", 7'(exp_q.size()), 7'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
